game_countdown: RTL and testbench



---
 rtl/game_countdown_if.sv | 25 ++
 rtl/game_countdown.sv | 172 +++++++++++++++++
 tb/tb_game_countdown.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/game_countdown_if.sv
// Strobe inputs and remaining-time outputs of the game countdown.
// The master side drives the strobes and the slave side is the counter.
interface game_countdown_if;
  logic       tick;
  logic       start;
  logic       pause;
  logic [6:0] seconds_left;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       running;
  logic       paused;
  logic       warn;
  logic       game_over;
  logic       done;

  modport master (
    output tick, start, pause,
    input  seconds_left, bcd_tens, bcd_ones, running, paused, warn, game_over, done
  );

  modport slave (
    input  tick, start, pause,
    output seconds_left, bcd_tens, bcd_ones, running, paused, warn, game_over, done
  );
endinterface

// File: rtl/game_countdown.sv
// Game-length countdown driven by the 1 Hz tick strobe, with pause/resume,
// low-time warning and end-of-game signalling in binary and two-digit BCD.
module game_countdown #(
  parameter int GAME_SECONDS = 60,
  parameter int WARN_SECONDS = 10
) (
  input  logic             clk_in,
  input  logic             rst_n,
  game_countdown_if.slave  cd
);

  generate
    if (GAME_SECONDS < 1 || GAME_SECONDS > 99) begin : g_bad_game_seconds
      $fatal(1, "game_countdown: GAME_SECONDS must be in 1..99");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int         WARN_CLAMP = (WARN_SECONDS > 127) ? 127 : ((WARN_SECONDS < 0) ? 0 : WARN_SECONDS);
  localparam logic [6:0] LOAD_SECS  = 7'(GAME_SECONDS);
  localparam logic [3:0] LOAD_TENS  = 4'(GAME_SECONDS / 10);
  localparam logic [3:0] LOAD_ONES  = 4'(GAME_SECONDS % 10);
  localparam logic [6:0] WARN_LIM   = 7'(WARN_CLAMP);

  // Two-digit BCD decrement with borrow from the tens digit.
  function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if (ones == 4'd0) begin
      res = {tens - 4'd1, 4'd9};
    end else begin
      res = {tens, ones - 4'd1};
    end
    return res;
  endfunction

  state_t     r_state;
  logic [6:0] r_secs;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_running;
  logic       r_paused;
  logic       r_warn;
  logic       r_game_over;
  logic       r_done;

  state_t     w_state_nxt;
  logic       w_load;
  logic       w_dec;
  logic       w_game_over_nxt;
  logic [6:0] w_secs_nxt;
  logic [3:0] w_tens_nxt;
  logic [3:0] w_ones_nxt;
  logic [7:0] w_bcd_dec;
  logic       w_warn_nxt;

  // Next-state decode; start outranks tick, and a tick is applied before a same-cycle pause.
  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_dec           = 1'b0;
    w_game_over_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cd.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUNNING;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUNNING: begin
        if (cd.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUNNING;
        end else if (cd.tick && (r_secs > 7'd1)) begin
          w_dec       = 1'b1;
          w_state_nxt = cd.pause ? S_PAUSED : S_RUNNING;
        end else if (cd.tick && (r_secs == 7'd1)) begin
          w_dec           = 1'b1;
          w_state_nxt     = S_DONE;
          w_game_over_nxt = 1'b1;
        end else if (cd.pause) begin
          w_state_nxt = S_PAUSED;
        end else begin
          w_state_nxt = S_RUNNING;
        end
      end
      S_PAUSED: begin
        if (cd.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUNNING;
        end else if (cd.pause) begin
          w_state_nxt = S_RUNNING;
        end else begin
          w_state_nxt = S_PAUSED;
        end
      end
      S_DONE: begin
        if (cd.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUNNING;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Count datapath: binary and BCD move together so they never disagree.
  always_comb begin
    w_bcd_dec  = bcd_dec(r_tens, r_ones);
    w_secs_nxt = r_secs;
    w_tens_nxt = r_tens;
    w_ones_nxt = r_ones;
    if (w_load) begin
      w_secs_nxt = LOAD_SECS;
      w_tens_nxt = LOAD_TENS;
      w_ones_nxt = LOAD_ONES;
    end else if (w_dec) begin
      w_secs_nxt = r_secs - 7'd1;
      w_tens_nxt = w_bcd_dec[7:4];
      w_ones_nxt = w_bcd_dec[3:0];
    end else begin
      w_secs_nxt = r_secs;
    end
    w_warn_nxt = ((w_state_nxt == S_RUNNING) || (w_state_nxt == S_PAUSED)) && (w_secs_nxt <= WARN_LIM);
  end

  // State, count and registered output flags.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_secs      <= LOAD_SECS;
      r_tens      <= LOAD_TENS;
      r_ones      <= LOAD_ONES;
      r_running   <= 1'b0;
      r_paused    <= 1'b0;
      r_warn      <= 1'b0;
      r_game_over <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_secs      <= w_secs_nxt;
      r_tens      <= w_tens_nxt;
      r_ones      <= w_ones_nxt;
      r_running   <= (w_state_nxt == S_RUNNING);
      r_paused    <= (w_state_nxt == S_PAUSED);
      r_warn      <= w_warn_nxt;
      r_game_over <= w_game_over_nxt;
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign cd.seconds_left = r_secs;
  assign cd.bcd_tens     = r_tens;
  assign cd.bcd_ones     = r_ones;
  assign cd.running      = r_running;
  assign cd.paused       = r_paused;
  assign cd.warn         = r_warn;
  assign cd.game_over    = r_game_over;
  assign cd.done         = r_done;

endmodule

// File: tb/tb_game_countdown.sv
// Directed bench for game_countdown: default 60 s instance plus 9 s and 99 s
// instances for the BCD load and borrow corner cases.
module tb_game_countdown;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   go_cnt = 0;

  always #5 clk = ~clk;

  game_countdown_if ifa ();
  game_countdown_if ifb ();
  game_countdown_if ifc ();

  game_countdown #(.GAME_SECONDS(60), .WARN_SECONDS(10)) dut_a (.clk_in(clk), .rst_n(rst_n), .cd(ifa));
  game_countdown #(.GAME_SECONDS(9),  .WARN_SECONDS(10)) dut_b (.clk_in(clk), .rst_n(rst_n), .cd(ifb));
  game_countdown #(.GAME_SECONDS(99), .WARN_SECONDS(10)) dut_c (.clk_in(clk), .rst_n(rst_n), .cd(ifc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic t, input logic s, input logic p);
    case (inst)
      0: begin ifa.tick = t; ifa.start = s; ifa.pause = p; end
      1: begin ifb.tick = t; ifb.start = s; ifb.pause = p; end
      default: begin ifc.tick = t; ifc.start = s; ifc.pause = p; end
    endcase
  endtask

  // One-cycle strobe; returns on the negedge after the capturing posedge.
  task automatic strobe(input int inst, input logic t, input logic s, input logic p);
    @(negedge clk);
    drive(inst, t, s, p);
    @(negedge clk);
    drive(inst, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int inst, input int n);
    for (int k = 0; k < n; k++) strobe(inst, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_a(input string tag, input int secs, input logic run, input logic pau,
                         input logic wrn, input logic go, input logic dn);
    check({tag, "_secs"}, ifa.seconds_left, secs);
    check({tag, "_tens"}, ifa.bcd_tens, secs / 10);
    check({tag, "_ones"}, ifa.bcd_ones, secs % 10);
    check({tag, "_run"},  ifa.running, run);
    check({tag, "_pau"},  ifa.paused, pau);
    check({tag, "_warn"}, ifa.warn, wrn);
    check({tag, "_go"},   ifa.game_over, go);
    check({tag, "_done"}, ifa.done, dn);
  endtask

  always @(negedge clk) begin
    if (ifa.game_over) go_cnt++;
    check("inv_a", ifa.bcd_tens * 10 + ifa.bcd_ones, ifa.seconds_left);
    check("inv_b", ifb.bcd_tens * 10 + ifb.bcd_ones, ifb.seconds_left);
    check("inv_c", ifc.bcd_tens * 10 + ifc.bcd_ones, ifc.seconds_left);
  end

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    drive(2, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_a("reset", 60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_b_tens", ifb.bcd_tens, 0);
    check("reset_b_ones", ifb.bcd_ones, 9);
    check("reset_c_tens", ifc.bcd_tens, 9);
    check("reset_c_ones", ifc.bcd_ones, 9);

    // Full 60-tick game.
    strobe(0, 1'b0, 1'b1, 1'b0);
    check_a("start", 60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      strobe(0, 1'b1, 1'b0, 1'b0);
      check_a("cnt", 60 - i, (i < 60), 1'b0, (i < 60) && ((60 - i) <= 10), (i == 60), (i == 60));
      repeat (98) @(negedge clk);
    end
    check("go_once", go_cnt, 1);
    strobe(0, 1'b1, 1'b0, 1'b1);
    check_a("tick61", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("go_still_once", go_cnt, 1);

    // Pause / resume.
    strobe(0, 1'b0, 1'b1, 1'b0);
    check_a("restart", 60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(0, 5);
    check_a("five", 55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(0, 1'b0, 1'b0, 1'b1);
    check_a("paused", 55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(0, 3);
    check_a("frozen", 55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    strobe(0, 1'b0, 1'b0, 1'b1);
    check_a("resumed", 55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(0, 1);
    check_a("after_resume", 54, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start beats a same-cycle tick.
    ticks(0, 34);
    check_a("at20", 20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(0, 1'b1, 1'b1, 1'b0);
    check_a("start_tick", 60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Final tick with a same-cycle pause ends the game; pause discarded.
    ticks(0, 59);
    check_a("at1", 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    strobe(0, 1'b1, 1'b0, 1'b1);
    check_a("tick_pause_end", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check_a("go_drop", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("go_twice", go_cnt, 2);
    strobe(0, 1'b0, 1'b1, 1'b0);
    check_a("reload_warn", 60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-game.
    ticks(0, 23);
    check_a("at37", 37, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_a("async_rst", 60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    strobe(0, 1'b1, 1'b0, 1'b0);
    strobe(0, 1'b0, 1'b0, 1'b1);
    check_a("idle_ignore", 60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // GAME_SECONDS = 9.
    strobe(1, 1'b0, 1'b1, 1'b0);
    check("b_load_secs", ifb.seconds_left, 9);
    check("b_load_tens", ifb.bcd_tens, 0);
    check("b_load_ones", ifb.bcd_ones, 9);
    check("b_load_warn", ifb.warn, 1);
    ticks(1, 1);
    check("b_dec_ones", ifb.bcd_ones, 8);

    // GAME_SECONDS = 99 with the 90 -> 89 borrow.
    strobe(2, 1'b0, 1'b1, 1'b0);
    check("c_load_tens", ifc.bcd_tens, 9);
    check("c_load_ones", ifc.bcd_ones, 9);
    check("c_load_warn", ifc.warn, 0);
    ticks(2, 9);
    check("c90_secs", ifc.seconds_left, 90);
    check("c90_tens", ifc.bcd_tens, 9);
    check("c90_ones", ifc.bcd_ones, 0);
    ticks(2, 1);
    check("c89_secs", ifc.seconds_left, 89);
    check("c89_tens", ifc.bcd_tens, 8);
    check("c89_ones", ifc.bcd_ones, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
